// File: rtl/replace_num_ctrl_pkg.sv
// replace_num_ctrl_pkg
// Shared constants for the replacement-number path of the delay-line harness:
// default data/address widths, the sequencer state encodings and the
// requester slot numbers used on the write-port arbiter.
package replace_num_ctrl_pkg;

  localparam int UART_REPLACE_NUM_DATA_WIDTH = 32;
  localparam int UART_REPLACE_NUM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    RNC_ERASE   = 2'd0,
    RNC_IDLE    = 2'd1,
    RNC_CAPTURE = 2'd2,
    RNC_OUT     = 2'd3
  } rnc_state_e;

  // Arbiter slots; slot 0 is also the arbiter's reset value for last_grant.
  localparam int REQ_STREAM = 0;
  localparam int REQ_WRITE  = 1;

endpackage

// File: rtl/replace_num_ctrl_if.sv
// replace_num_ctrl_if
// Bundles the stream input, stream output, UART write handshake and the
// memory-side signals of replace_num_ctrl.
//   slave  : the controller's view (replace_num_ctrl)
//   master : the surrounding harness view (source, sink, UART decoder, memory)
interface replace_num_ctrl_if
  import replace_num_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = UART_REPLACE_NUM_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_REPLACE_NUM_ADDR_WIDTH
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_replaced;
  logic                  wr_req;
  logic                  wr_ack;
  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_valid;
  logic                  mem_n_reset;
  logic                  busy;

  modport slave (
    input  in_data, in_valid, out_ready, wr_req, mem_data, mem_valid,
    output in_ready, out_data, out_valid, out_replaced, wr_ack,
           mem_wr_en, mem_rd_en, mem_rd_addr, mem_n_reset, busy
  );

  modport master (
    output in_data, in_valid, out_ready, wr_req, mem_data, mem_valid,
    input  in_ready, out_data, out_valid, out_replaced, wr_ack,
           mem_wr_en, mem_rd_en, mem_rd_addr, mem_n_reset, busy
  );
endinterface

// File: rtl/replace_num_ctrl_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. A lone request is granted at once; when
// both request, the one not granted last time wins.
//   clk, n_reset : clock, synchronous active-low reset (last_grant -> slot 0)
//   en           : arbitration allowed this cycle
//   req[1:0]     : requests
//   gnt[1:0]     : one-hot (or zero) grant, combinational
module rr_arb2 (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) begin
        gnt = last_grant ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      last_grant <= 1'b0;
    end else if (gnt[1]) begin
      last_grant <= 1'b1;
    end else if (gnt[0]) begin
      last_grant <= 1'b0;
    end
  end
endmodule

// File: rtl/replace_num_ctrl.sv
// replace_num_ctrl
// Numbers each outgoing stream word with a wrapping sequence index, reads the
// replacement memory at that index and substitutes the stored word when it is
// valid. Shares the memory write port between UART write packets and the
// stream, and drives the memory erase reset after every controller reset.
//   clk, n_reset : clock, synchronous active-low reset
//   bus          : replace_num_ctrl_if.slave (stream in/out, wr_req/wr_ack,
//                  memory read/write/erase, busy)
//
// state       | meaning
// ------------+--------------------------------------------------------------
// RNC_ERASE   | memory held in erase for 2**ADDR_WIDTH+1 cycles, no grants
// RNC_IDLE    | arbitrate stream word vs UART write
// RNC_CAPTURE | memory read data valid; no write so the read-clear executes
// RNC_OUT     | output word held until out_ready
module replace_num_ctrl
  import replace_num_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = UART_REPLACE_NUM_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_REPLACE_NUM_ADDR_WIDTH
) (
  input logic               clk,
  input logic               n_reset,
  replace_num_ctrl_if.slave bus
);
  // Last erase cycle: the count of 2**ADDR_WIDTH (counter starts at 0), so the
  // erase spans depth+1 cycles, the extra one draining the memory's write stage.
  localparam logic [ADDR_WIDTH:0] ERASE_TC = {1'b1, {ADDR_WIDTH{1'b0}}};

  rnc_state_e            state, state_nxt;
  logic [ADDR_WIDTH:0]   erase_ctr;
  logic [ADDR_WIDTH-1:0] seq;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic                  out_replaced_r;

  logic                  arb_en;
  logic [1:0]            req, gnt;
  logic                  erase_done;

  assign erase_done = (erase_ctr == ERASE_TC);

  assign req[REQ_STREAM] = bus.in_valid;
  assign req[REQ_WRITE]  = bus.wr_req;

  rr_arb2 u_arb (
    .clk     (clk),
    .n_reset (n_reset),
    .en      (arb_en),
    .req     (req),
    .gnt     (gnt)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= RNC_ERASE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RNC_ERASE:   if (erase_done) state_nxt = RNC_IDLE;
      RNC_IDLE:    if (gnt[REQ_STREAM]) state_nxt = RNC_CAPTURE;
      RNC_CAPTURE: state_nxt = RNC_OUT;
      RNC_OUT:     if (bus.out_ready) state_nxt = RNC_IDLE;
      default:     state_nxt = RNC_ERASE;
    endcase
  end

  // Grants only exist in IDLE, so a write can never land on a read cycle or
  // on the CAPTURE cycle that the memory uses for its read-clear.
  always_comb begin
    arb_en          = (state == RNC_IDLE);
    bus.in_ready    = gnt[REQ_STREAM];
    bus.mem_rd_en   = gnt[REQ_STREAM];
    bus.wr_ack      = gnt[REQ_WRITE];
    bus.mem_wr_en   = gnt[REQ_WRITE];
    bus.mem_n_reset = (state != RNC_ERASE);
    bus.busy        = (state == RNC_ERASE);
  end

  assign bus.mem_rd_addr  = seq;
  assign bus.out_data     = out_data_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_replaced = out_replaced_r;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      erase_ctr      <= '0;
      seq            <= '0;
      hold_reg       <= '0;
      out_data_r     <= '0;
      out_valid_r    <= 1'b0;
      out_replaced_r <= 1'b0;
    end else begin
      if (state == RNC_ERASE) begin
        erase_ctr <= erase_ctr + 1'b1;
      end
      if (gnt[REQ_STREAM]) begin
        hold_reg <= bus.in_data;
      end
      if (state == RNC_CAPTURE) begin
        out_data_r     <= bus.mem_valid ? bus.mem_data : hold_reg;
        out_replaced_r <= bus.mem_valid;
        out_valid_r    <= 1'b1;
        seq            <= seq + 1'b1;
      end else if (state == RNC_OUT && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_replace_num_ctrl.sv
// tb_replace_num_ctrl
// Self-checking bench for replace_num_ctrl with ADDR_WIDTH=2. Contains a
// read-then-clear memory model, a scoreboard fed by a replacement reference
// model, a vector table and hand-written erase/arbitration/reset sequences.
module tb_replace_num_ctrl;
  import replace_num_ctrl_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  replace_num_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  replace_num_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory model: write packet wired from the UART side ----
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem_d [DEPTH];
  logic          mem_v [DEPTH];
  logic [DW-1:0] rd_d = '0;
  logic          rd_v = 1'b0;
  logic          clr_pend = 1'b0;
  logic [AW-1:0] clr_addr = '0;

  assign bus.mem_data  = rd_d;
  assign bus.mem_valid = rd_v;

  always @(posedge clk) begin
    if (bus.mem_n_reset !== 1'b1) begin
      for (int i = 0; i < DEPTH; i++) mem_v[i] <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      if (bus.mem_wr_en === 1'b1) begin
        mem_v[wr_addr] <= 1'b1;
        mem_d[wr_addr] <= wr_data;
      end
      if (bus.mem_rd_en === 1'b1) begin
        rd_d     <= mem_d[bus.mem_rd_addr];
        rd_v     <= mem_v[bus.mem_rd_addr];
        clr_pend <= 1'b1;
        clr_addr <= bus.mem_rd_addr;
      end else if (bus.mem_wr_en !== 1'b1) begin
        if (clr_pend) mem_v[clr_addr] <= 1'b0;
        clr_pend <= 1'b0;
      end
    end
  end

  // ---------------- reference model + scoreboard ---------------------------
  typedef struct {
    logic [DW-1:0] data;
    logic          repl;
    longint        acc_cyc;
  } exp_t;

  exp_t          sb[$];
  bit            ref_v [DEPTH];
  logic [DW-1:0] ref_d [DEPTH];
  int            ref_seq = 0;
  logic          prev_rd = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
  logic [DW-1:0] prev_od = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!n_reset) begin
      sb.delete();
      for (int i = 0; i < DEPTH; i++) ref_v[i] = 1'b0;
      ref_seq = 0;
      prev_rd = 1'b0;
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (bus.mem_wr_en) begin
        chk("wr_collides_read", {62'd0, bus.mem_rd_en, prev_rd}, 64'd0);
        chk("wr_ack_eq_wr_en", bus.wr_ack, 1);
        ref_v[wr_addr] = 1'b1;
        ref_d[wr_addr] = wr_data;
      end
      if (bus.in_valid && bus.in_ready) begin
        chk("rd_addr", bus.mem_rd_addr, ref_seq);
        chk("rd_en_with_accept", bus.mem_rd_en, 1);
        e.repl    = ref_v[ref_seq];
        e.data    = ref_v[ref_seq] ? ref_d[ref_seq] : bus.in_data;
        e.acc_cyc = cyc;
        ref_v[ref_seq] = 1'b0;
        ref_seq = (ref_seq + 1) % DEPTH;
        sb.push_back(e);
      end
      if (prev_ov && !prev_or) begin
        chk("out_valid_held", bus.out_valid, 1);
        chk("out_data_held", bus.out_data, prev_od);
      end
      if (bus.out_valid && !prev_ov) begin
        chk("out_has_accept", sb.size() != 0, 1);
        if (sb.size() != 0) chk("latency", cyc - sb[0].acc_cyc, 2);
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_out_data", bus.out_data, e.data);
        chk("sb_out_replaced", bus.out_replaced, e.repl);
      end
      prev_rd = bus.mem_rd_en;
      prev_ov = bus.out_valid;
      prev_or = bus.out_ready;
      prev_od = bus.out_data;
    end
  end

  // ---------------- driver tasks --------------------------------------------
  task automatic erase_check();
    int lows = 0;
    bit viol = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("erase_out_valid", bus.out_valid, 0);
        chk("erase_busy", bus.busy, 1);
      end
      if (bus.mem_n_reset) break;
      lows++;
      if (bus.in_ready || bus.wr_ack || bus.mem_rd_en) viol = 1'b1;
    end
    chk("erase_len", lows, DEPTH + 1);
    chk("erase_blocking", viol, 0);
    chk("busy_after_erase", bus.busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    erase_check();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k = 0;
    @(posedge clk); #1;
    wr_addr = a;
    wr_data = d;
    bus.wr_req = 1'b1;
    do begin @(negedge clk); k++; end while (!bus.wr_ack && k < 50);
    chk("wr_ack_seen", bus.wr_ack, 1);
    @(posedge clk); #1 bus.wr_req = 1'b0;
  endtask

  task automatic do_stream(input logic [DW-1:0] w, output logic [DW-1:0] got,
                           output logic repl, output logic [AW-1:0] raddr);
    int k = 0;
    @(posedge clk); #1;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    do begin @(negedge clk); k++; end while (!bus.in_ready && k < 50);
    chk("in_ready_seen", bus.in_ready, 1);
    raddr = bus.mem_rd_addr;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.out_valid && k < 50);
    chk("out_valid_seen", bus.out_valid, 1);
    got  = bus.out_data;
    repl = bus.out_replaced;
  endtask

  // ---------------- vector table --------------------------------------------
  typedef enum {OP_RESET, OP_WRITE, OP_STREAM} op_e;
  typedef struct {
    op_e           op;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_data;
    logic          exp_repl;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got;
    logic          repl;
    logic [AW-1:0] raddr;
    int            g, g_prev, ng;
    bit            acc, wack;

    // passthrough
    vecs.push_back('{OP_RESET,  2'd0, 32'h0,    32'h0,    1'b0});
    vecs.push_back('{OP_STREAM, 2'd0, 32'h11,   32'h11,   1'b0});
    vecs.push_back('{OP_STREAM, 2'd0, 32'h22,   32'h22,   1'b0});
    vecs.push_back('{OP_STREAM, 2'd0, 32'h33,   32'h33,   1'b0});
    // replacement at seq 1
    vecs.push_back('{OP_RESET,  2'd0, 32'h0,    32'h0,    1'b0});
    vecs.push_back('{OP_WRITE,  2'd1, 32'hDEAD, 32'h0,    1'b0});
    vecs.push_back('{OP_STREAM, 2'd0, 32'hA0,   32'hA0,   1'b0});
    vecs.push_back('{OP_STREAM, 2'd0, 32'hA1,   32'hDEAD, 1'b1});
    vecs.push_back('{OP_STREAM, 2'd0, 32'hA2,   32'hA2,   1'b0});
    // clear after use: seq wraps to 0 on word 4, entry already consumed
    vecs.push_back('{OP_RESET,  2'd0, 32'h0,    32'h0,    1'b0});
    vecs.push_back('{OP_WRITE,  2'd0, 32'hBEEF, 32'h0,    1'b0});
    vecs.push_back('{OP_STREAM, 2'd0, 32'h100,  32'hBEEF, 1'b1});
    for (int i = 1; i < 8; i++)
      vecs.push_back('{OP_STREAM, 2'd0, 32'h100 + i, 32'h100 + i, 1'b0});

    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h55;
    bus.wr_req    = 1'b0;
    bus.out_ready = 1'b1;

    // reset state, then first erase with a word already waiting
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_replaced", bus.out_replaced, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_mem_wr_en", bus.mem_wr_en, 0);
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_mem_n_reset", bus.mem_n_reset, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 1);
    @(posedge clk); #1 n_reset = 1'b1;
    erase_check();
    chk("in_ready_after_erase", bus.in_ready, 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_RESET: do_reset();
        OP_WRITE: do_write(vecs[i].addr, vecs[i].din);
        default: begin
          do_stream(vecs[i].din, got, repl, raddr);
          chk("vec_out_data", got, vecs[i].exp_data);
          chk("vec_out_replaced", repl, vecs[i].exp_repl);
        end
      endcase
    end

    // arbitration: both requesters held high, grants must alternate
    @(posedge clk); #1;
    wr_addr = 2'd3;
    wr_data = 32'hA5A5;
    bus.wr_req   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h700;
    g_prev = -1;
    ng = 0;
    for (int i = 0; i < 60 && ng < 6; i++) begin
      @(negedge clk);
      g = -1;
      if (bus.in_ready || bus.wr_ack) begin
        chk("single_grant", bus.in_ready & bus.wr_ack, 0);
        g = bus.wr_ack ? 1 : 0;
        if (g_prev >= 0) chk("rr_alternate", g, 1 - g_prev);
        g_prev = g;
        ng++;
      end
      @(posedge clk); #1;
      if (g == 0) bus.in_data = bus.in_data + 1;
    end
    chk("arb_grant_count", ng, 6);
    bus.in_valid = 1'b0;
    bus.wr_req   = 1'b0;
    repeat (6) @(posedge clk);

    // reset while a word is held in OUT
    #1;
    bus.out_ready = 1'b0;
    bus.in_data   = 32'h900;
    bus.in_valid  = 1'b1;
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.in_ready && g < 50);
    chk("midout_accept", bus.in_ready, 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.out_valid && g < 50);
    chk("midout_holding", bus.out_valid, 1);
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b0;
    @(posedge clk); #1 n_reset = 1'b1;
    bus.out_ready = 1'b1;
    erase_check();
    do_stream(32'h777, got, repl, raddr);
    chk("seq_restart", raddr, 0);
    chk("after_reset_data", got, 32'h777);
    repeat (3) @(posedge clk);

    // randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      acc  = bus.in_valid & bus.in_ready;
      wack = bus.wr_ack;
      @(posedge clk); #1;
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 2) != 0);
        bus.in_data  = $urandom;
      end
      if (!bus.wr_req || wack) begin
        bus.wr_req = ($urandom_range(0, 3) == 0);
        wr_addr    = 2'($urandom_range(0, DEPTH - 1));
        wr_data    = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.wr_req = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.wr_req    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/replace_num_ctrl.md
Name: replace_num_ctrl

Overview:
Sequencer and arbiter in front of the replacement-number memory in the delay-line test harness. It numbers each word of the outgoing sample stream with a wrapping sequence index and reads the memory at that index. It substitutes the stored replacement when one is valid, and shares the memory write port between UART-decoded write requests and the stream. It also generates the memory's erase reset and keeps the memory's read-then-clear timing rule intact.

Parameters:
DATA_WIDTH, 32, width of stream words and replacement data
ADDR_WIDTH, 8, memory address width; depth and sequence wrap = 2**ADDR_WIDTH

Ports:
clk  in  1  clock
n_reset  in  1  reset, synchronous, active-low; clock clk
in_data  in  DATA_WIDTH  upstream sample word
in_valid  in  1  upstream word available
in_ready  out  1  word accepted this cycle when in_valid & in_ready
out_data  out  DATA_WIDTH  sample or replacement word
out_valid  out  1  out_data valid; held until out_ready
out_ready  in  1  downstream accepts
out_replaced  out  1  out_data came from memory (qualified by out_valid)
wr_req  in  1  UART decoder has a write packet; packet wired directly to memory
wr_ack  out  1  write granted this cycle; requester drops/advances packet
mem_wr_en  out  1  memory write enable (== wr_ack)
mem_rd_en  out  1  memory read enable
mem_rd_addr  out  ADDR_WIDTH  memory read address (= seq)
mem_data  in  DATA_WIDTH  memory read data, 1-cycle latency after mem_rd_en
mem_valid  in  1  memory valid flag, same timing as mem_data
mem_n_reset  out  1  memory erase reset, active-low
busy  out  1  high while erasing

Behaviour:
- Reset (n_reset low at clk edge): state ERASE, erase_ctr=0, seq=0, last_grant=STREAM. The following outputs are 0: out_valid, out_replaced, in_ready, wr_ack, mem_wr_en, mem_rd_en, mem_n_reset. out_data=0, busy=1.
- ERASE: mem_n_reset=0. erase_ctr counts while n_reset high. Go to IDLE after 2**ADDR_WIDTH+1 cycles; the +1 covers the memory's write pipeline stage. Then mem_n_reset=1 and busy=0.
- ERASE blocking: no in_ready, wr_ack or mem_rd_en during ERASE.
- IDLE: candidates are in_valid and wr_req.
  - Only one present: grant it.
  - Both present: grant the one opposite to last_grant (round-robin, no starvation).
- Write grant: wr_ack=mem_wr_en=1 combinationally for one cycle; last_grant=WRITE; stay IDLE.
- Stream grant: in_ready=1, mem_rd_en=1 and mem_rd_addr=seq, all combinationally. Register in_data into hold_reg. last_grant=STREAM. Go to CAPTURE.
- CAPTURE: mem_data/mem_valid are valid this cycle. mem_wr_en forced 0, so the memory's pending clear executes. The memory's clear requires a non-write cycle after each read; CAPTURE provides it.
- CAPTURE registers: out_data = mem_valid ? mem_data : hold_reg; out_replaced=mem_valid; out_valid=1; seq=seq+1 mod 2**ADDR_WIDTH. Go to OUT.
- OUT: hold out_data/out_valid stable until out_ready. On out_valid&out_ready: out_valid=0, go to IDLE. No grants in OUT.
- Latency/throughput: accept at cycle t gives out_valid at t+2. Max throughput is 1 word per 3 cycles with out_ready held high.
- Writes only in IDLE, so no write ever coincides with a read or CAPTURE cycle.
- seq wrap: 2**ADDR_WIDTH-1 increments to 0; no flag.
- Reset mid-operation: any state returns to ERASE. In-flight word and pending out word are discarded; out_valid drops next cycle; memory is fully re-erased.
- Upstream stability: wr_req deasserting without ack is legal. in_valid must stay high until in_ready.

Decomposition:
- Shared header uart_msg_consts.h provides the DATA_WIDTH/ADDR_WIDTH defaults (UART_REPLACE_NUM_DATA_WIDTH / ADDR_WIDTH).
- Add to the same header: state encodings RNC_ERASE, RNC_IDLE, RNC_CAPTURE, RNC_OUT.
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter with a last_grant register, reusable elsewhere in the harness.

Test Plan:
- Erase: release n_reset, ADDR_WIDTH=2 -> mem_n_reset low exactly 5 cycles, busy low and in_ready possible from cycle 6.
- Passthrough: no writes, stream 0x11,0x22,0x33, out_ready=1 -> outputs 0x11,0x22,0x33, out_replaced=0, each out_valid 2 cycles after accept; mem_rd_addr 0,1,2.
- Replacement: write addr 1 data 0xDEAD, stream 0xA0,0xA1,0xA2 -> outputs 0xA0,0xDEAD(out_replaced=1),0xA2.
- Clear after use: ADDR_WIDTH=2, write addr 0 data 0xBEEF, stream 8 words -> word 0 replaced; word 4 (seq wrapped to 0) passthrough.
- Arbitration: wr_req and in_valid held high together from IDLE -> grants alternate; no mem_wr_en in any CAPTURE cycle or cycle with mem_rd_en.
- Reset mid-OUT: out_ready=0 holding word, assert n_reset 1 cycle -> out_valid 0 next cycle, full erase replays, seq restarts at 0.
